// File: rtl/pin_compress_seq_pkg.sv
// Shared definitions for the pin gather engine: FSM encodings and count-width helper.
// Shared with pin_decompress users; encodings must stay numerically stable.
package pin_compress_seq_pkg;

    typedef logic [1:0] pin_state_t;

    localparam pin_state_t PIN_ST_IDLE = 2'd0;
    localparam pin_state_t PIN_ST_SCAN = 2'd1;
    localparam pin_state_t PIN_ST_DONE = 2'd2;

    function automatic int unsigned pin_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/pin_compress_seq_if.sv
// Handshake bundle for pin_compress_seq: input word/mask stream and packed result stream.
interface pin_compress_seq_if
    import pin_compress_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CNT_W = pin_cnt_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

endinterface

// File: rtl/pin_compress_seq_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of i_vec, plus an any-set flag.
module lowest_set_bit #(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (i_vec[i-1]) begin
                o_idx = IDX_W'(i - 1);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_compress_seq.sv
// Sequential pin gather: packs data bits at mask-set positions into result LSBs.
// Define PIN_COMPRESS_SKIP_EN to scan only masked bits via a priority encoder.
module pin_compress_seq
    import pin_compress_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pin_compress_seq_if.slave bus
);

    localparam int unsigned CNT_W = pin_cnt_w(WIDTH);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    pin_state_t       r_state;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_out_data;
    logic [CNT_W-1:0] r_out_count;

    logic             w_take;
    logic             w_bit;
    logic             w_finish;
    logic [WIDTH-1:0] w_acc_next;

`ifdef PIN_COMPRESS_SKIP_EN
    logic [IDX_W-1:0] w_low;
    logic             w_any;
    logic [WIDTH-1:0] w_m_next;

    lowest_set_bit #(.WIDTH(WIDTH)) u_lsb (
        .i_vec (r_m),
        .o_idx (w_low),
        .o_any (w_any)
    );

    assign w_take   = w_any;
    assign w_bit    = r_d[w_low];
    assign w_finish = !w_any;

    always_comb begin
        w_m_next        = r_m;
        w_m_next[w_low] = 1'b0;
    end
`else
    logic [IDX_W-1:0] r_idx;
    logic             r_flush;

    assign w_take   = r_m[r_idx];
    assign w_bit    = r_d[r_idx];
    assign w_finish = r_flush;
`endif

    always_comb begin
        w_acc_next = r_acc;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_take && (CNT_W'(i) == r_cnt)) begin
                w_acc_next[i] = w_bit;
            end
        end
    end

    // Results are loaded one edge after the last bit is absorbed, so both builds
    // share the WIDTH+1 worst-case latency and the same output-load path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PIN_ST_IDLE;
            r_d         <= '0;
            r_m         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
`ifndef PIN_COMPRESS_SKIP_EN
            r_idx       <= '0;
            r_flush     <= 1'b0;
`endif
        end else begin
            case (r_state)
                PIN_ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_d     <= bus.in_data;
                        r_m     <= bus.in_mask;
                        r_acc   <= '0;
                        r_cnt   <= '0;
`ifndef PIN_COMPRESS_SKIP_EN
                        r_idx   <= '0;
                        r_flush <= 1'b0;
`endif
                        r_state <= PIN_ST_SCAN;
                    end
                end
                PIN_ST_SCAN: begin
                    if (w_finish) begin
                        r_out_data  <= r_acc;
                        r_out_count <= r_cnt;
                        r_state     <= PIN_ST_DONE;
                    end else begin
                        if (w_take) begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
`ifdef PIN_COMPRESS_SKIP_EN
                        r_m <= w_m_next;
`else
                        r_idx <= r_idx + IDX_W'(1);
                        if (r_idx == IDX_W'(WIDTH - 1)) begin
                            r_flush <= 1'b1;
                        end
`endif
                    end
                end
                PIN_ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= PIN_ST_IDLE;
                    end
                end
                default: r_state <= PIN_ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (r_state == PIN_ST_IDLE);
    assign bus.out_valid = (r_state == PIN_ST_DONE);
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;

endmodule

// File: tb/tb_pin_compress_seq.sv
// Scoreboard bench for pin_compress_seq: directed vectors, backpressure, reset and random words.
module tb_pin_compress_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] m;
        logic [W-1:0] ed;
        logic [4:0]   ec;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pin_compress_seq_if #(.WIDTH(W)) bus ();

    pin_compress_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gather(input logic [W-1:0] d, input logic [W-1:0] m);
        logic [W-1:0] r = '0;
        int           j = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                r[j] = d[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] scatter(input logic [W-1:0] p, input logic [W-1:0] m);
        logic [W-1:0] r = '0;
        int           j = 0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                r[i] = p[j];
                j++;
            end
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] m);
`ifdef PIN_COMPRESS_SKIP_EN
        return $countones(m) + 1;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: a handshake completes at the next posedge whenever both are high here.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h with empty scoreboard", bus.out_data);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(mon_e.ed));
                chk("out_count", 32'(bus.out_count), 32'(mon_e.ec));
                chk("scatter_roundtrip", 32'(scatter(bus.out_data, mon_e.m)), 32'(mon_e.d & mon_e.m));
            end
        end
    end

    task automatic run_vec(input logic [W-1:0] d, input logic [W-1:0] m, input logic [W-1:0] ed,
                           input logic [4:0] ec, input int stall);
        int n;
        bit bad;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        q.push_back('{d, m, ed, ec});
        bus.in_data  = d;
        bus.in_mask  = m;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        bus.in_data = ~d;
        bus.in_mask = ~m;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        bus.out_ready = 1'b0;
        if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        else                chk("latency", 32'(n), 32'(exp_lat(m)));
        bad = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.in_ready || bus.out_data !== ed || bus.out_count !== ec) bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (stall > 0) chk("backpressure_hold", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("in_ready_after_out", 32'(bus.in_ready), 32'd1);
        chk("out_valid_after_out", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] m;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data", 32'(bus.out_data), 32'd0);
        chk("reset_out_count", 32'(bus.out_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);

        run_vec(16'h0105, 16'h5145, 16'h000B, 5'd6, 0);
        run_vec(16'hFFFF, 16'h0000, 16'h0000, 5'd0, 0);
        run_vec(16'hA5C3, 16'hFFFF, 16'hA5C3, 5'd16, 0);
        run_vec(16'h8000, 16'h8000, 16'h0001, 5'd1, 0);
        run_vec(16'hFFFF, 16'hAAAA, 16'h00FF, 5'd8, 1);
        run_vec(16'h5555, 16'hFF00, 16'h0055, 5'd8, 2);
        run_vec(16'h00F0, 16'h0FF0, 16'h000F, 5'd8, 20);

        // Reset five edges into a scan drops the word.
        @(posedge clk); #1;
        bus.in_data  = 16'h1234;
        bus.in_mask  = 16'hFFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midscan_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("midscan_rst_out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midscan_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        run_vec(16'h8001, 16'h8001, 16'h0003, 5'd2, 0);

        for (int k = 0; k < 1000; k++) begin
            d = W'($urandom);
            m = W'($urandom);
            if (k % 50 == 0) m = '1;
            if (k % 50 == 1) m = '0;
            run_vec(d, m, gather(d, m), 5'($countones(m)), int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
